// File: rtl/nts_api_bridge.sv
// Host-to-API bridge: one outstanding read/write, range-checked, with an optional
// response counter block enabled by defining NTS_API_BRIDGE_COUNTERS_EN.
module nts_api_bridge #(
  parameter int          READ_LATENCY = 1,
  parameter logic [11:0] ADDR_LAST    = 12'h2FF
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [11:0] i_req_address,
  input  logic [31:0] i_req_write_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_read_data,
  output logic        o_rsp_error,
  output logic        o_api_cs,
  output logic        o_api_we,
  output logic [11:0] o_api_address,
  output logic [31:0] o_api_write_data,
  input  logic [31:0] i_api_read_data,
  output logic [15:0] o_cnt_reads,
  output logic [15:0] o_cnt_writes,
  output logic [15:0] o_cnt_errors
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // WAIT spans READ_LATENCY cycles; the counter reaching zero marks the sample cycle.
  localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

  state_t      state_reg;
  logic        we_reg;
  logic [11:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [1:0]  wait_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state_reg        <= IDLE;
      we_reg           <= 1'b0;
      addr_reg         <= 12'h000;
      wdata_reg        <= 32'h0;
      wait_cnt_reg     <= 2'd0;
      o_req_ready      <= 1'b1;
      o_rsp_valid      <= 1'b0;
      o_rsp_read_data  <= 32'h0;
      o_rsp_error      <= 1'b0;
      o_api_cs         <= 1'b0;
      o_api_we         <= 1'b0;
      o_api_address    <= 12'h000;
      o_api_write_data <= 32'h0;
    end else begin
      o_api_cs         <= 1'b0;
      o_api_we         <= 1'b0;
      o_api_address    <= 12'h000;
      o_api_write_data <= 32'h0;
      case (state_reg)
        IDLE: begin
          if (i_req_valid) begin
            we_reg      <= i_req_we;
            addr_reg    <= i_req_address;
            wdata_reg   <= i_req_write_data;
            o_req_ready <= 1'b0;
            if (i_req_address <= ADDR_LAST) begin
              state_reg        <= ISSUE;
              o_api_cs         <= 1'b1;
              o_api_we         <= i_req_we;
              o_api_address    <= i_req_address;
              o_api_write_data <= i_req_write_data;
            end else begin
              state_reg       <= RESP;
              o_rsp_valid     <= 1'b1;
              o_rsp_error     <= 1'b1;
              o_rsp_read_data <= 32'h0;
            end
          end
        end
        ISSUE: begin
          if (we_reg) begin
            state_reg       <= RESP;
            o_rsp_valid     <= 1'b1;
            o_rsp_error     <= 1'b0;
            o_rsp_read_data <= 32'h0;
          end else begin
            state_reg    <= WAIT;
            wait_cnt_reg <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 2'd0) begin
            state_reg       <= RESP;
            o_rsp_valid     <= 1'b1;
            o_rsp_error     <= 1'b0;
            o_rsp_read_data <= i_api_read_data;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 2'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            state_reg       <= IDLE;
            o_rsp_valid     <= 1'b0;
            o_rsp_error     <= 1'b0;
            o_rsp_read_data <= 32'h0;
            o_req_ready     <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef NTS_API_BRIDGE_COUNTERS_EN
  logic [15:0] cnt_reads_reg;
  logic [15:0] cnt_writes_reg;
  logic [15:0] cnt_errors_reg;
  logic        rsp_done;

  // The error flag and latched direction stay valid throughout RESP.
  assign rsp_done = o_rsp_valid && i_rsp_ready;

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      cnt_reads_reg  <= 16'h0;
      cnt_writes_reg <= 16'h0;
      cnt_errors_reg <= 16'h0;
    end else if (rsp_done) begin
      if (o_rsp_error) begin
        if (cnt_errors_reg != 16'hFFFF) cnt_errors_reg <= cnt_errors_reg + 16'd1;
      end else if (we_reg) begin
        if (cnt_writes_reg != 16'hFFFF) cnt_writes_reg <= cnt_writes_reg + 16'd1;
      end else begin
        if (cnt_reads_reg != 16'hFFFF) cnt_reads_reg <= cnt_reads_reg + 16'd1;
      end
    end
  end

  assign o_cnt_reads  = cnt_reads_reg;
  assign o_cnt_writes = cnt_writes_reg;
  assign o_cnt_errors = cnt_errors_reg;
`else
  assign o_cnt_reads  = 16'h0;
  assign o_cnt_writes = 16'h0;
  assign o_cnt_errors = 16'h0;
`endif

endmodule
